// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline: load-use stalls, branch squash, memory freeze.
// Optional performance counters are built only when HAZARD_STATS_EN is defined.
module pipeline_hazard_controller #(
    parameter int LOAD_STALL_CYCLES = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [4:0]  ID_RS1,
    input  logic [4:0]  ID_RS2,
    input  logic        ID_USES_RS1,
    input  logic        ID_USES_RS2,
    input  logic [4:0]  EX_RD,
    input  logic        EX_MEM_READ,
    input  logic        BRANCH_TAKEN,
    input  logic        IMEM_BUSYWAIT,
    input  logic        DMEM_BUSYWAIT,
    output logic        PC_WRITE_EN,
    output logic        IF_ID_HOLD,
    output logic        IF_ID_FLUSH,
    output logic        ID_EX_BUBBLE,
    output logic        GLOBAL_HOLD,
    output logic [1:0]  CTRL_STATE,
    output logic [31:0] STALL_COUNT,
    output logic [31:0] FLUSH_COUNT
);
    localparam int STALL_CYC = (LOAD_STALL_CYCLES < 1 || LOAD_STALL_CYCLES > 3) ? 1 : LOAD_STALL_CYCLES;
    localparam logic [1:0] STALL_INIT = 2'(STALL_CYC - 1);

    typedef enum logic [1:0] {RUN = 2'b00, LOAD_STALL = 2'b01, FLUSH = 2'b10, MEM_WAIT = 2'b11} state_t;

    state_t     state, state_nxt;
    logic [1:0] cnt, cnt_nxt;
    logic       mem_busy, load_use;

    assign mem_busy    = IMEM_BUSYWAIT | DMEM_BUSYWAIT;
    assign load_use    = EX_MEM_READ && (EX_RD != 5'd0) &&
                         ((ID_USES_RS1 && EX_RD == ID_RS1) || (ID_USES_RS2 && EX_RD == ID_RS2));
    assign GLOBAL_HOLD = mem_busy && !RESET;
    assign CTRL_STATE  = state;

    always_comb begin
        PC_WRITE_EN  = 1'b1;
        IF_ID_HOLD   = 1'b0;
        IF_ID_FLUSH  = 1'b0;
        ID_EX_BUBBLE = 1'b0;
        state_nxt    = state;
        cnt_nxt      = cnt;
        if (mem_busy) begin
            PC_WRITE_EN = 1'b0;
            if (state == RUN)
                state_nxt = MEM_WAIT;
        end else begin
            case (state)
                LOAD_STALL: begin
                    PC_WRITE_EN  = 1'b0;
                    IF_ID_HOLD   = 1'b1;
                    ID_EX_BUBBLE = 1'b1;
                    cnt_nxt      = cnt - 2'd1;
                    if (cnt == 2'd1)
                        state_nxt = RUN;
                end
                FLUSH: state_nxt = RUN;
                default: begin
                    // A drained MEM_WAIT acts on whatever hazard the frozen pipeline now shows.
                    state_nxt = RUN;
                    if (BRANCH_TAKEN) begin
                        IF_ID_FLUSH  = 1'b1;
                        ID_EX_BUBBLE = 1'b1;
                        state_nxt    = FLUSH;
                    end else if (load_use) begin
                        PC_WRITE_EN  = 1'b0;
                        IF_ID_HOLD   = 1'b1;
                        ID_EX_BUBBLE = 1'b1;
                        if (STALL_CYC > 1) begin
                            state_nxt = LOAD_STALL;
                            cnt_nxt   = STALL_INIT;
                        end
                    end
                end
            endcase
        end
        if (RESET) begin
            PC_WRITE_EN  = 1'b0;
            IF_ID_HOLD   = 1'b0;
            IF_ID_FLUSH  = 1'b1;
            ID_EX_BUBBLE = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= RUN;
            cnt   <= 2'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_q, flush_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!PC_WRITE_EN && stall_q != '1)
                stall_q <= stall_q + 32'd1;
            // Outside reset the only source of IF_ID_FLUSH is a taken branch.
            if (IF_ID_FLUSH && flush_q != '1)
                flush_q <= flush_q + 32'd1;
        end
    end

    assign STALL_COUNT = stall_q;
    assign FLUSH_COUNT = flush_q;
`else
    assign STALL_COUNT = '0;
    assign FLUSH_COUNT = '0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: three builds (1, 3 and clamped 5 stall cycles) against one model.
module tb_pipeline_hazard_controller;
    typedef struct {
        bit       rst;
        bit [4:0] rs1, rs2;
        bit       u1, u2;
        bit [4:0] rd;
        bit       mr, br, ib, db;
    } vin_t;

    typedef struct {
        vin_t     in;
        bit       pc, hd, fl, bb, gh;
        bit [1:0] st;
    } vec_t;

    typedef struct {
        int          stall_left;
        bit          flush_next;
        bit          waiting;
        int unsigned stalls, flushes;
    } mst_t;

    localparam int PEFF[3] = '{1, 3, 1};

    logic CLK = 1'b0, RESET = 1'b1;
    logic [4:0] ID_RS1 = '0, ID_RS2 = '0, EX_RD = '0;
    logic ID_USES_RS1 = 0, ID_USES_RS2 = 0, EX_MEM_READ = 0, BRANCH_TAKEN = 0;
    logic IMEM_BUSYWAIT = 0, DMEM_BUSYWAIT = 0;
    logic [2:0] pc_we, hold, flush, bubble, ghold;
    logic [2:0][1:0]  st;
    logic [2:0][31:0] scnt, fcnt;

    int total = 0, bad = 0;
    mst_t m[3];
    vec_t tbl[$];

    always #5 CLK = ~CLK;

    pipeline_hazard_controller #(.LOAD_STALL_CYCLES(1)) u1 (
        .CLK(CLK), .RESET(RESET), .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .ID_USES_RS1(ID_USES_RS1),
        .ID_USES_RS2(ID_USES_RS2), .EX_RD(EX_RD), .EX_MEM_READ(EX_MEM_READ), .BRANCH_TAKEN(BRANCH_TAKEN),
        .IMEM_BUSYWAIT(IMEM_BUSYWAIT), .DMEM_BUSYWAIT(DMEM_BUSYWAIT), .PC_WRITE_EN(pc_we[0]),
        .IF_ID_HOLD(hold[0]), .IF_ID_FLUSH(flush[0]), .ID_EX_BUBBLE(bubble[0]), .GLOBAL_HOLD(ghold[0]),
        .CTRL_STATE(st[0]), .STALL_COUNT(scnt[0]), .FLUSH_COUNT(fcnt[0]));
    pipeline_hazard_controller #(.LOAD_STALL_CYCLES(3)) u3 (
        .CLK(CLK), .RESET(RESET), .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .ID_USES_RS1(ID_USES_RS1),
        .ID_USES_RS2(ID_USES_RS2), .EX_RD(EX_RD), .EX_MEM_READ(EX_MEM_READ), .BRANCH_TAKEN(BRANCH_TAKEN),
        .IMEM_BUSYWAIT(IMEM_BUSYWAIT), .DMEM_BUSYWAIT(DMEM_BUSYWAIT), .PC_WRITE_EN(pc_we[1]),
        .IF_ID_HOLD(hold[1]), .IF_ID_FLUSH(flush[1]), .ID_EX_BUBBLE(bubble[1]), .GLOBAL_HOLD(ghold[1]),
        .CTRL_STATE(st[1]), .STALL_COUNT(scnt[1]), .FLUSH_COUNT(fcnt[1]));
    pipeline_hazard_controller #(.LOAD_STALL_CYCLES(5)) u5 (
        .CLK(CLK), .RESET(RESET), .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .ID_USES_RS1(ID_USES_RS1),
        .ID_USES_RS2(ID_USES_RS2), .EX_RD(EX_RD), .EX_MEM_READ(EX_MEM_READ), .BRANCH_TAKEN(BRANCH_TAKEN),
        .IMEM_BUSYWAIT(IMEM_BUSYWAIT), .DMEM_BUSYWAIT(DMEM_BUSYWAIT), .PC_WRITE_EN(pc_we[2]),
        .IF_ID_HOLD(hold[2]), .IF_ID_FLUSH(flush[2]), .ID_EX_BUBBLE(bubble[2]), .GLOBAL_HOLD(ghold[2]),
        .CTRL_STATE(st[2]), .STALL_COUNT(scnt[2]), .FLUSH_COUNT(fcnt[2]));

    function automatic vec_t V(int rst, int rs1, int rs2, int u1, int u2, int rd, int mr, int br,
                               int ib, int db, int pc, int hd, int fl, int bb, int gh, int s);
        vec_t v;
        v.in.rst = (rst != 0); v.in.rs1 = 5'(rs1); v.in.rs2 = 5'(rs2);
        v.in.u1 = (u1 != 0); v.in.u2 = (u2 != 0); v.in.rd = 5'(rd); v.in.mr = (mr != 0);
        v.in.br = (br != 0); v.in.ib = (ib != 0); v.in.db = (db != 0);
        v.pc = (pc != 0); v.hd = (hd != 0); v.fl = (fl != 0); v.bb = (bb != 0); v.gh = (gh != 0);
        v.st = 2'(s);
        return v;
    endfunction

    function automatic mst_t mzero();
        mst_t s;
        s.stall_left = 0; s.flush_next = 0; s.waiting = 0; s.stalls = 0; s.flushes = 0;
        return s;
    endfunction

    // Reference behaviour: remaining stall cycles, pending flush cycle and memory-wait flag.
    function automatic void mout(input mst_t s, input vin_t v, output bit pc, output bit hd,
                                 output bit fl, output bit bb, output bit gh, output bit [1:0] so);
        bit busy = v.ib | v.db;
        bit lu = v.mr && v.rd != 0 && ((v.u1 && v.rd == v.rs1) || (v.u2 && v.rd == v.rs2));
        pc = 1; hd = 0; fl = 0; bb = 0; gh = busy;
        so = s.waiting ? 2'd3 : s.flush_next ? 2'd2 : (s.stall_left > 0) ? 2'd1 : 2'd0;
        if (v.rst) begin
            pc = 0; fl = 1; bb = 1; gh = 0; so = 0;
        end else if (busy) begin
            pc = 0;
        end else if (s.stall_left > 0) begin
            pc = 0; hd = 1; bb = 1;
        end else if (s.flush_next) begin
            pc = 1;
        end else if (v.br) begin
            fl = 1; bb = 1;
        end else if (lu) begin
            pc = 0; hd = 1; bb = 1;
        end
    endfunction

    function automatic mst_t mstep(input mst_t s, input vin_t v, input int p);
        bit pc, hd, fl, bb, gh;
        bit [1:0] so;
        bit lu = v.mr && v.rd != 0 && ((v.u1 && v.rd == v.rs1) || (v.u2 && v.rd == v.rs2));
        mst_t n = s;
        if (v.rst) return mzero();
        mout(s, v, pc, hd, fl, bb, gh, so);
        if (!pc && n.stalls != 32'hFFFF_FFFF) n.stalls++;
        if (fl && n.flushes != 32'hFFFF_FFFF) n.flushes++;
        if (v.ib | v.db) begin
            if (!s.waiting && !s.flush_next && s.stall_left == 0) n.waiting = 1;
        end else if (s.stall_left > 0) begin
            n.stall_left = s.stall_left - 1;
        end else if (s.flush_next) begin
            n.flush_next = 0;
        end else begin
            n.waiting = 0;
            if (v.br) n.flush_next = 1;
            else if (lu) n.stall_left = p - 1;
        end
        return n;
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[u%0d] got=%0h want=%0h t=%0t", nm, k, act, exp, $time);
        end
    endtask

    task automatic drive_check(input vin_t v);
        bit pc, hd, fl, bb, gh;
        bit [1:0] so;
        @(negedge CLK);
        RESET = v.rst; ID_RS1 = v.rs1; ID_RS2 = v.rs2; ID_USES_RS1 = v.u1; ID_USES_RS2 = v.u2;
        EX_RD = v.rd; EX_MEM_READ = v.mr; BRANCH_TAKEN = v.br; IMEM_BUSYWAIT = v.ib; DMEM_BUSYWAIT = v.db;
        if (v.rst) for (int k = 0; k < 3; k++) m[k] = mzero();
        #2;
        for (int k = 0; k < 3; k++) begin
            mout(m[k], v, pc, hd, fl, bb, gh, so);
            chk("pc_write_en", k, 32'(pc_we[k]), 32'(pc));
            chk("if_id_hold", k, 32'(hold[k]), 32'(hd));
            chk("if_id_flush", k, 32'(flush[k]), 32'(fl));
            chk("id_ex_bubble", k, 32'(bubble[k]), 32'(bb));
            chk("global_hold", k, 32'(ghold[k]), 32'(gh));
            chk("ctrl_state", k, 32'(st[k]), 32'(so));
`ifdef HAZARD_STATS_EN
            chk("stall_count", k, scnt[k], m[k].stalls);
            chk("flush_count", k, fcnt[k], m[k].flushes);
`else
            chk("stall_count", k, scnt[k], 32'd0);
            chk("flush_count", k, fcnt[k], 32'd0);
`endif
        end
    endtask

    task automatic advance(input vin_t v);
        @(posedge CLK);
        for (int k = 0; k < 3; k++) m[k] = mstep(m[k], v, PEFF[k]);
    endtask

    initial begin
        vin_t r;
        for (int k = 0; k < 3; k++) m[k] = mzero();
        // Directed sequence; expected columns are for the 3-cycle build.
        tbl.push_back(V(1,0,0,0,0,0,0,0,0,0, 0,0,1,1,0,0));  // reset
        tbl.push_back(V(0,0,0,0,0,0,0,0,0,0, 1,0,0,0,0,0));
        tbl.push_back(V(0,1,5,1,1,5,1,0,0,0, 0,1,0,1,0,0));  // lw x5 / use rs2=5
        tbl.push_back(V(0,1,5,1,1,5,1,0,0,0, 0,1,0,1,0,1));
        tbl.push_back(V(0,1,5,1,1,5,1,0,0,0, 0,1,0,1,0,1));
        tbl.push_back(V(0,0,0,0,0,0,0,0,0,0, 1,0,0,0,0,0));
        tbl.push_back(V(0,0,0,1,0,0,1,0,0,0, 1,0,0,0,0,0));  // EX_RD=0: no stall
        tbl.push_back(V(0,1,5,1,1,5,1,1,0,0, 1,0,1,1,0,0));  // branch beats load-use
        tbl.push_back(V(0,1,5,1,1,5,1,1,0,0, 1,0,0,0,0,2));  // FLUSH ignores held branch
        tbl.push_back(V(0,0,0,0,0,0,0,0,0,0, 1,0,0,0,0,0));
        tbl.push_back(V(0,1,5,1,1,5,1,0,0,0, 0,1,0,1,0,0));
        tbl.push_back(V(0,1,5,1,1,5,1,0,0,0, 0,1,0,1,0,1));
        tbl.push_back(V(1,1,5,1,1,5,1,0,0,0, 0,0,1,1,0,0));  // reset mid-stall
        tbl.push_back(V(0,0,0,0,0,0,0,0,0,0, 1,0,0,0,0,0));
        tbl.push_back(V(0,1,5,1,1,5,1,0,0,0, 0,1,0,1,0,0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(V(0,1,5,1,1,5,1,0,0,1, 0,0,0,0,1,1));  // dmem busy freezes stall
        tbl.push_back(V(0,1,5,1,1,5,1,0,0,0, 0,1,0,1,0,1));
        tbl.push_back(V(0,1,5,1,1,5,1,0,0,0, 0,1,0,1,0,1));
        tbl.push_back(V(0,0,0,0,0,0,0,0,0,0, 1,0,0,0,0,0));
        tbl.push_back(V(0,0,0,0,0,0,0,1,1,0, 0,0,0,0,1,0));  // imem busy + branch
        tbl.push_back(V(0,0,0,0,0,0,0,1,1,0, 0,0,0,0,1,3));
        tbl.push_back(V(0,0,0,0,0,0,0,1,0,0, 1,0,1,1,0,3));  // flush once busy drops
        tbl.push_back(V(0,0,0,0,0,0,0,1,0,0, 1,0,0,0,0,2));
        tbl.push_back(V(0,0,0,0,0,0,0,0,0,0, 1,0,0,0,0,0));
        tbl.push_back(V(0,5,0,1,0,5,0,0,0,0, 1,0,0,0,0,0));  // not a load
        tbl.push_back(V(0,0,5,0,0,5,1,0,0,0, 1,0,0,0,0,0));  // rs2 not used

        foreach (tbl[i]) begin
            drive_check(tbl[i].in);
            chk("tbl_pc", 1, 32'(pc_we[1]), 32'(tbl[i].pc));
            chk("tbl_hold", 1, 32'(hold[1]), 32'(tbl[i].hd));
            chk("tbl_flush", 1, 32'(flush[1]), 32'(tbl[i].fl));
            chk("tbl_bubble", 1, 32'(bubble[1]), 32'(tbl[i].bb));
            chk("tbl_ghold", 1, 32'(ghold[1]), 32'(tbl[i].gh));
            chk("tbl_state", 1, 32'(st[1]), 32'(tbl[i].st));
            advance(tbl[i].in);
        end

        for (int i = 0; i < 800; i++) begin
            r.rst = ($urandom_range(0, 63) == 0);
            r.rs1 = 5'($urandom_range(0, 3)); r.rs2 = 5'($urandom_range(0, 3));
            r.rd  = 5'($urandom_range(0, 3));
            r.u1 = 1'($urandom); r.u2 = 1'($urandom); r.mr = 1'($urandom);
            r.br = ($urandom_range(0, 5) == 0);
            r.ib = ($urandom_range(0, 7) == 0); r.db = ($urandom_range(0, 7) == 0);
            drive_check(r);
            advance(r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
